// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shift unit beside the ALU.
// Shifts an operand by a variable amount, at most STEP bits per clock, in SLL/SRL/SRA modes.
// Requests and results use valid/ready handshakes.
// Optional feature macro: SEQ_SHIFTER_ROTATE_EN.
//   Defined:   op = 2'b11 rotates right (ROR).
//   Undefined: op = 2'b11 behaves as SLL and no rotate logic is built.
module seq_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1,
  localparam int unsigned SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  // One extra bit so that STEP == WIDTH and WIDTH itself are representable.
  localparam logic [SHW:0] StepW  = STEP[SHW:0];
`ifdef SEQ_SHIFTER_ROTATE_EN
  localparam logic [SHW:0] WidthW = WIDTH[SHW:0];
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [SHW:0]     rem_ext;
  logic [SHW:0]     step_k;
  logic [SHW-1:0]   rem_next;
  logic [WIDTH-1:0] shifted;

  // One shift step: k = min(STEP, remaining); the last step may be partial, so no over-shift.
  always_comb begin
    rem_ext  = {1'b0, rem_q};
    step_k   = (rem_ext < StepW) ? rem_ext : StepW;
    rem_next = rem_q - step_k[SHW-1:0];
    shifted  = data_q << step_k;
    unique case (op_q)
      2'b00: shifted = data_q << step_k;
      2'b01: shifted = data_q >> step_k;
      // Sign fill comes from the MSB of the current data value.
      2'b10: shifted = $signed(data_q) >>> step_k;
`ifdef SEQ_SHIFTER_ROTATE_EN
      // step_k is never zero while shifting, so the left shift stays below WIDTH.
      2'b11: shifted = (data_q >> step_k) | (data_q << (WidthW - step_k));
`else
      2'b11: shifted = data_q << step_k;
`endif
      default: shifted = data_q;
    endcase
  end

  // Next-state logic: accept in IDLE, step in SHIFT, hold the result in DONE until taken.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    rem_d    = rem_q;
    op_d     = op_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d = a;
          op_d   = op;
          rem_d  = shamt;
          if (shamt == '0) begin
            state_d  = StDone;
            result_d = a;
          end else begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        data_d = shifted;
        rem_d  = rem_next;
        if (rem_next == '0) begin
          state_d  = StDone;
          result_d = shifted;
        end
      end
      StDone: begin
        // No accept here even if in_valid is high: this is the one-cycle bubble.
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      data_q   <= '0;
      rem_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  // Handshake and status outputs decode directly from the state register.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    result    = result_q;
  end

endmodule
